cla16_seq_adder: RTL and testbench

//   Multi-word sequential adder. Time-shares one cla16 instance over WORDS 16-bit

---
 rtl/cla16_seq_adder.sv | 195 +++++++++++++++++++
 tb/tb_cla16_seq_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla16_seq_adder.sv
// cla16_seq_adder: multi-word sequential adder built around one 16-bit
// carry-lookahead slice (cla16). Operands are processed least significant
// 16-bit slice first, one slice per clock, with the inter-slice carry held in
// a register. Start/done handshake; result held until the next accept.
// Optional feature: define CLA16_SEQ_SUB_EN to add a 'sub' input that turns
// the operation into A - B (two's complement, cout=1 means no borrow).

// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
module cla16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        ci,
   output logic [15:0] s,
   output logic        co
);
   logic [15:0] p;
   logic [15:0] g;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  pg;
   logic [4:0]  gc;

   // Bit/group propagate-generate, group carries, then in-group carries and sum
   always_comb begin
      // NOTE: every variable gets a default before any conditional or partial
      // assignment so no latch can be inferred.
      p  = a ^ b;
      g  = a & b;
      c  = '0;
      gg = '0;
      pg = '0;
      gc = '0;
      gc[0] = ci;
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pg[k] = &p[4*k +: 4];
         gc[k+1] = gg[k] | (pg[k] & gc[k]);
      end
      for (int k = 0; k < 4; k++) begin
         c[4*k] = gc[k];
         for (int j = 0; j < 3; j++) begin
            c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
         end
      end
      s  = p ^ c;
      co = gc[4];
   end
endmodule

module cla16_seq_adder #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
`ifdef CLA16_SEQ_SUB_EN
   input  logic                sub,
`endif
   input  logic [16*WORDS-1:0] op_a,
   input  logic [16*WORDS-1:0] op_b,
   input  logic                cin,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic [16*WORDS-1:0] sum,
   output logic                cout
);
   localparam int W  = 16 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;

   logic [15:0]     slice_a;
   logic [15:0]     slice_b;
   logic [15:0]     slice_s;
   logic            slice_co;
   logic            accept;

   assign ready  = (state_q == IDLE) || (state_q == DONE);
   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign sum    = sum_q;
   assign cout   = cout_q;
   assign accept = start && ready;

   // Select the current operand slice for the shared adder
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_q == IW'(i)) begin
            slice_a = a_q[16*i +: 16];
            slice_b = b_q[16*i +: 16];
         end
      end
   end

   cla16 u_cla16 (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   // Next-state and datapath updates: accept, per-slice write, completion
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         RUN: begin
            for (int i = 0; i < WORDS; i++) begin
               if (idx_q == IW'(i)) begin
                  sum_d[16*i +: 16] = slice_s;
               end
            end
            carry_d = slice_co;
            if (idx_q == IW'(WORDS - 1)) begin
               // Last slice: its carry is the result carry; idx parks at 0
               cout_d  = slice_co;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Accept overrides the IDLE/DONE transitions above (back-to-back from DONE)
      if (accept) begin
         a_d     = op_a;
         idx_d   = '0;
         state_d = RUN;
`ifdef CLA16_SEQ_SUB_EN
         b_d     = sub ? ~op_b : op_b;
         carry_d = sub ? 1'b1 : cin;
`else
         b_d     = op_b;
         carry_d = cin;
`endif
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand and result registers are reset too, so an aborted
         // operation leaves no stale data visible on sum/cout.
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed in the combinational block.
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end
endmodule

// File: tb/tb_cla16_seq_adder.sv
// Directed testbench for cla16_seq_adder (WORDS=4 main instance, WORDS=1
// boundary instance). Subtract-mode vectors apply when CLA16_SEQ_SUB_EN is set.
module tb_cla16_seq_adder;
   logic        clk;
   logic        rst_n;

   logic        start;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        cin;
   logic        ready;
   logic        busy;
   logic        done;
   logic [63:0] sum;
   logic        cout;
`ifdef CLA16_SEQ_SUB_EN
   logic        sub;
`endif

   logic        start1;
   logic [15:0] op_a1;
   logic [15:0] op_b1;
   logic        cin1;
   logic        ready1;
   logic        busy1;
   logic        done1;
   logic [15:0] sum1;
   logic        cout1;
`ifdef CLA16_SEQ_SUB_EN
   logic        sub1;
`endif

   int n_cmp;
   int n_err;

   cla16_seq_adder #(.WORDS(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
`ifdef CLA16_SEQ_SUB_EN
      .sub   (sub),
`endif
      .op_a  (op_a),
      .op_b  (op_b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   cla16_seq_adder #(.WORDS(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
`ifdef CLA16_SEQ_SUB_EN
      .sub   (sub1),
`endif
      .op_a  (op_a1),
      .op_b  (op_b1),
      .cin   (cin1),
      .ready (ready1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge (the accept edge), then drop start
   task automatic accept_op(input logic [63:0] a, input logic [63:0] b, input logic c);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      cin   = c;
      tick();
      start = 1'b0;
   endtask

   // Edges after the accept edge until done; bounded
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   int lat;
   int n_done;
   int n_busy_low;

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      cin   = 1'b0;
      start1 = 1'b0;
      op_a1  = '0;
      op_b1  = '0;
      cin1   = 1'b0;
`ifdef CLA16_SEQ_SUB_EN
      sub  = 1'b0;
      sub1 = 1'b0;
`endif

      // Reset state
      #1;
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_busy",  64'(busy),  64'd0);
      check("rst_done",  64'(done),  64'd0);
      check("rst_sum",   sum,        64'd0);
      check("rst_cout",  64'(cout),  64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: carry ripples through every slice
      accept_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
      check("t1_busy_after_accept", 64'(busy), 64'd1);
      wait_done(lat);
      check("t1_latency", 64'(lat), 64'd4);
      check("t1_sum",  sum,       64'h0);
      check("t1_cout", 64'(cout), 64'd1);
      check("t1_ready_in_done", 64'(ready), 64'd1);
      tick();
      check("t1_done_one_cycle", 64'(done), 64'd0);
      check("t1_sum_held", sum, 64'h0);

      // 2: mixed slices; slice 0 (CC28+4C88) carries into slice 1 (00A8+4CA8+1)
      accept_op(64'h0000_0C28_00A8_CC28, 64'h4CBA_4CAA_4CA8_4C88, 1'b0);
      wait_done(lat);
      check("t2_latency", 64'(lat), 64'd4);
      check("t2_sum",  sum,       64'h4CBA_58D2_4D51_18B0);
      check("t2_cout", 64'(cout), 64'd0);
      tick();

      // 3: start held for 10 edges with operands changing every cycle;
      // accepts happen at k=0 (1+0) and k=5 (6+500)
      n_done = 0;
      n_busy_low = 0;
      start = 1'b1;
      for (int k = 0; k < 10; k++) begin
         op_a = 64'(k + 1);
         op_b = 64'(100 * k);
         cin  = 1'b0;
         tick();
         if (done) n_done++;
         if (!busy && k != 4 && k != 9) n_busy_low++;
         if (k == 4) check("t3_first_sum", sum, 64'd1);
      end
      start = 1'b0;
      check("t3_second_sum", sum, 64'd506);
      check("t3_done_count", 64'(n_done), 64'd2);
      check("t3_busy_gaps", 64'(n_busy_low), 64'd0);
      tick();
      check("t3_no_third_accept", 64'(busy), 64'd0);

      // 4: reset asserted during the third RUN cycle
      accept_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_rst_busy",  64'(busy),  64'd0);
      check("t4_rst_ready", 64'(ready), 64'd1);
      check("t4_rst_sum",   sum,        64'd0);
      check("t4_rst_cout",  64'(cout),  64'd0);
      tick();
      #2;
      rst_n = 1'b1;
      n_done = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (done) n_done++;
      end
      check("t4_no_done", 64'(n_done), 64'd0);
      accept_op(64'd1, 64'd1, 1'b0);
      wait_done(lat);
      check("t4_sum_after", sum, 64'd2);

      // 5: back-to-back; start presented in the DONE cycle
      tick();
      accept_op(64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b0);
      wait_done(lat);
      check("t5_first_sum", sum, 64'h0000_0000_0001_FFFF);
      accept_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1);
      check("t5_done_dropped", 64'(done), 64'd0);
      check("t5_sum_kept", sum, 64'h0000_0000_0001_FFFF);
      wait_done(lat);
      check("t5_second_latency", 64'(lat), 64'd4);
      check("t5_second_sum",  sum,       64'h0000_0000_0000_0002);
      check("t5_second_cout", 64'(cout), 64'd1);
      tick();

      // WORDS=1 boundary: one RUN cycle, done after the second edge
      start1 = 1'b1;
      op_a1  = 16'hFFFF;
      op_b1  = 16'h0001;
      cin1   = 1'b0;
      tick();
      start1 = 1'b0;
      check("w1_busy", 64'(busy1), 64'd1);
      tick();
      check("w1_done", 64'(done1), 64'd1);
      check("w1_sum",  64'(sum1),  64'd0);
      check("w1_cout", 64'(cout1), 64'd1);
      tick();

`ifdef CLA16_SEQ_SUB_EN
      // 6: subtract mode; cin is ignored when sub=1
      sub = 1'b1;
      accept_op(64'd5, 64'd7, 1'b0);
      wait_done(lat);
      check("t6_sub_sum_neg",  sum,       64'hFFFF_FFFF_FFFF_FFFE);
      check("t6_sub_cout_neg", 64'(cout), 64'd0);
      tick();
      accept_op(64'd7, 64'd5, 1'b0);
      wait_done(lat);
      check("t6_sub_sum_pos",  sum,       64'd2);
      check("t6_sub_cout_pos", 64'(cout), 64'd1);
      sub = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
